// File: rtl/bch_dec_ctrl.sv
// BCH(15,7) t=2 decoder sequencer: syndrome -> BM -> Chien -> corrected out.
// Ports: in_* word handshake, syn_*/bm_*/chien_* datapath links, out_* result.
module bch_dec_ctrl #(
  parameter int unsigned BM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_data,
  output logic        syn_start,
  output logic [14:0] syn_data,
  input  logic        syn_done,
  input  logic [3:0]  syn_s1,
  input  logic [3:0]  syn_s2,
  input  logic [3:0]  syn_s3,
  output logic [3:0]  bm_s1,
  output logic [3:0]  bm_s2,
  output logic [3:0]  bm_s3,
  input  logic [3:0]  bm_lambda1,
  input  logic [3:0]  bm_lambda2,
  output logic [3:0]  chien_pos,
  output logic [3:0]  chien_lambda1,
  output logic [3:0]  chien_lambda2,
  input  logic        chien_root,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_data,
  output logic [1:0]  out_err_cnt,
  output logic        out_fail
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYN, S_BM, S_CHIEN, S_OUT
  } state_e;

  localparam logic [2:0] BmLast = 3'(BM_LAT);

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [14:0] word_q, word_d;
  logic [3:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  l1_q, l1_d, l2_q, l2_d;
  logic [1:0]  deg_q, deg_d;
  logic [3:0]  pos_q, pos_d;
  logic [14:0] mask_q, mask_d;
  logic [1:0]  rcnt_q, rcnt_d;
  logic [14:0] od_q, od_d;
  logic [1:0]  oe_q, oe_d;
  logic        of_q, of_d;

  // Mask/count including this cycle's Chien result, so the last
  // position is folded in on the same edge that leaves CHIEN.
  logic [14:0] mask_nx;
  logic [1:0]  rcnt_nx;
  logic        fail_nx;

  always_comb begin
    mask_nx = mask_q;
    rcnt_nx = rcnt_q;
    if (chien_root) begin
      mask_nx = mask_q | (15'd1 << pos_q);
      if (rcnt_q != 2'd3) rcnt_nx = rcnt_q + 2'd1;
    end
    fail_nx = (rcnt_nx != deg_q) || (deg_q == 2'd0);
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    word_d  = word_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    cnt_d   = cnt_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    deg_d   = deg_q;
    pos_d   = pos_q;
    mask_d  = mask_q;
    rcnt_d  = rcnt_q;
    od_d    = od_q;
    oe_d    = oe_q;
    of_d    = of_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          mask_d  = '0;
          rcnt_d  = '0;
          cnt_d   = '0;
          start_d = 1'b1;
          state_d = S_SYN;
        end
      end
      S_SYN: begin
        if (syn_done) begin
          s1_d = syn_s1;
          s2_d = syn_s2;
          s3_d = syn_s3;
          if ((syn_s1 | syn_s2 | syn_s3) == 4'd0) begin
            od_d    = word_q;
            oe_d    = 2'd0;
            of_d    = 1'b0;
            state_d = S_OUT;
          end else begin
            state_d = S_BM;
          end
        end
      end
      S_BM: begin
        if (cnt_q == BmLast) begin
          l1_d    = bm_lambda1;
          l2_d    = bm_lambda2;
          deg_d   = (bm_lambda2 != 4'd0) ? 2'd2 :
                    (bm_lambda1 != 4'd0) ? 2'd1 : 2'd0;
          pos_d   = 4'd0;
          state_d = S_CHIEN;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_CHIEN: begin
        mask_d = mask_nx;
        rcnt_d = rcnt_nx;
        if (pos_q == 4'd14) begin
          od_d    = fail_nx ? word_q : (word_q ^ mask_nx);
          oe_d    = fail_nx ? 2'd0 : rcnt_nx;
          of_d    = fail_nx;
          pos_d   = 4'd0;
          state_d = S_OUT;
        end else begin
          pos_d = pos_q + 4'd1;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      word_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      cnt_q   <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      deg_q   <= '0;
      pos_q   <= '0;
      mask_q  <= '0;
      rcnt_q  <= '0;
      od_q    <= '0;
      oe_q    <= '0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      word_q  <= word_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      cnt_q   <= cnt_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      deg_q   <= deg_d;
      pos_q   <= pos_d;
      mask_q  <= mask_d;
      rcnt_q  <= rcnt_d;
      od_q    <= od_d;
      oe_q    <= oe_d;
      of_q    <= of_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_OUT);
  assign syn_start     = start_q;
  assign syn_data      = word_q;
  assign bm_s1         = s1_q;
  assign bm_s2         = s2_q;
  assign bm_s3         = s3_q;
  assign chien_pos     = pos_q;
  assign chien_lambda1 = l1_q;
  assign chien_lambda2 = l2_q;
  assign out_data      = od_q;
  assign out_err_cnt   = oe_q;
  assign out_fail      = of_q;

endmodule

// File: tb/tb_bch_dec_ctrl.sv
// Scoreboard bench for bch_dec_ctrl with stubbed syndrome/BM/Chien units.
// Driver pushes expected results; monitor pops and compares on out handshake.
module tb_bch_dec_ctrl;
  localparam int BM_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [14:0] in_data;
  logic syn_start, syn_done;
  logic [14:0] syn_data;
  logic [3:0] syn_s1, syn_s2, syn_s3;
  logic [3:0] bm_s1, bm_s2, bm_s3;
  logic [3:0] bm_lambda1, bm_lambda2;
  logic [3:0] chien_pos, chien_lambda1, chien_lambda2;
  logic chien_root;
  logic out_valid, out_ready;
  logic [14:0] out_data;
  logic [1:0] out_err_cnt;
  logic out_fail;

  bch_dec_ctrl #(.BM_LAT(BM_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .syn_start(syn_start), .syn_data(syn_data), .syn_done(syn_done),
    .syn_s1(syn_s1), .syn_s2(syn_s2), .syn_s3(syn_s3),
    .bm_s1(bm_s1), .bm_s2(bm_s2), .bm_s3(bm_s3),
    .bm_lambda1(bm_lambda1), .bm_lambda2(bm_lambda2),
    .chien_pos(chien_pos),
    .chien_lambda1(chien_lambda1), .chien_lambda2(chien_lambda2),
    .chien_root(chien_root),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err_cnt(out_err_cnt), .out_fail(out_fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [14:0] data;
    logic [1:0]  err;
    logic        fail;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];

  logic [14:0] roots_v = '0;
  logic [3:0]  cur_l1 = '0, cur_l2 = '0;
  int rdy_mode = 0;
  int hs_cyc = 0;
  int last_acc = 0;

  assign chien_root = (chien_pos < 4'd15) ? roots_v[chien_pos] : 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: samples just after the negedge, once the driver has settled.
  initial begin : mon
    logic prev_v;
    logic [14:0] pd;
    logic [1:0] pe;
    logic pf;
    exp_t e;
    prev_v = 1'b0;
    pd = '0; pe = '0; pf = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          check("in_ready_in_out", 32'(in_ready), 32'd0);
          if (prev_v) begin
            check("hold_data", 32'(out_data), 32'(pd));
            check("hold_err", 32'(out_err_cnt), 32'(pe));
            check("hold_fail", 32'(out_fail), 32'(pf));
          end else if (q.size() > 0) begin
            check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
          end
          pd = out_data; pe = out_err_cnt; pf = out_fail;
          prev_v = 1'b1;
          if (out_ready) begin
            hs_cyc = cyc + 1;
            prev_v = 1'b0;
            if (q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_output: got data %0h expected none",
                       out_data);
            end else begin
              e = q.pop_front();
              check("out_data", 32'(out_data), 32'(e.data));
              check("out_err_cnt", 32'(out_err_cnt), 32'(e.err));
              check("out_fail", 32'(out_fail), 32'(e.fail));
            end
          end
        end else begin
          prev_v = 1'b0;
        end
        if (chien_pos != 4'd0) begin
          check("chien_lambda", {24'd0, chien_lambda2, chien_lambda1},
                {24'd0, cur_l2, cur_l1});
        end
      end
    end
  end

  // Reference model: decode result from the stub values by the spec rules.
  task automatic start_word(input logic [14:0] d, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [3:0] s3,
                            input logic [3:0] l1, input logic [3:0] l2,
                            input logic [14:0] roots, input int L);
    exp_t e;
    int pc, cnt, deg, t;
    if (s1 == 0 && s2 == 0 && s3 == 0) begin
      e.data = d; e.err = 2'd0; e.fail = 1'b0; e.lat = L;
    end else begin
      pc  = $countones(roots);
      cnt = (pc > 3) ? 3 : pc;
      deg = (l2 != 0) ? 2 : (l1 != 0) ? 1 : 0;
      e.fail = (cnt != deg) || (deg == 0);
      e.data = e.fail ? d : (d ^ roots);
      e.err  = e.fail ? 2'd0 : 2'(cnt);
      e.lat  = L + BM_LAT + 1 + 15;
    end
    in_valid = 1'b1;
    in_data = d;
    bm_lambda1 = 4'($urandom);
    bm_lambda2 = 4'($urandom);
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    last_acc = e.acc;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 15'($urandom);
    check("syn_start", 32'(syn_start), 32'd1);
    check("syn_data", 32'(syn_data), 32'(d));
    repeat (L - 1) begin
      @(negedge clk);
      check("syn_start_once", 32'(syn_start), 32'd0);
    end
    syn_done = 1'b1;
    syn_s1 = s1; syn_s2 = s2; syn_s3 = s3;
    bm_lambda1 = l1; bm_lambda2 = l2;
    cur_l1 = l1; cur_l2 = l2;
    roots_v = roots;
    @(negedge clk);
    syn_done = 1'b0;
    syn_s1 = 4'($urandom); syn_s2 = 4'($urandom); syn_s3 = 4'($urandom);
    check("bm_s", {20'd0, bm_s3, bm_s2, bm_s1}, {20'd0, s3, s2, s1});
  endtask

  task automatic finish_word(input bit clean);
    int t;
    bit moved;
    t = 0;
    moved = 1'b0;
    while (q.size() != 0 && t < 300) begin
      @(negedge clk);
      if (chien_pos != 4'd0) moved = 1'b1;
      t++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL output_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    if (clean) check("clean_no_chien", 32'(moved), 32'd0);
  endtask

  task automatic run(input logic [14:0] d, input logic [3:0] s1,
                     input logic [3:0] s2, input logic [3:0] s3,
                     input logic [3:0] l1, input logic [3:0] l2,
                     input logic [14:0] roots, input int L);
    start_word(d, s1, s2, s3, l1, l2, roots, L);
    finish_word((s1 | s2 | s3) == 4'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t, typ, p1, p2;
    logic [3:0] s1, s2, s3, l1, l2;
    logic [14:0] roots;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; syn_done = 1'b0;
    syn_s1 = '0; syn_s2 = '0; syn_s3 = '0;
    bm_lambda1 = '0; bm_lambda2 = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_syn_start", 32'(syn_start), 32'd0);
    check("rst_chien_pos", 32'(chien_pos), 32'd0);
    check("rst_syn_data", 32'(syn_data), 32'd0);
    check("rst_bm_s", {20'd0, bm_s3, bm_s2, bm_s1}, 32'd0);
    check("rst_lambda", {24'd0, chien_lambda2, chien_lambda1}, 32'd0);
    check("rst_out", {14'd0, out_fail, out_err_cnt, out_data}, 32'd0);

    run(15'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 15'h0, 1);
    run(15'h0088, 4'h3, 4'h5, 4'h6, 4'h3, 4'h9, 15'h0088, 3);
    run(15'h0001, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 15'h0001, 1);
    run(15'h1234, 4'h7, 4'h2, 4'h9, 4'h2, 4'h5, 15'h0020, 2);

    rdy_mode = 1;
    out_ready = 1'b0;
    start_word(15'h4100, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 15'h0100, 1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (10) @(negedge clk);
    rdy_mode = 2;
    out_ready = 1'b1;
    start_word(15'h7fff, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 15'h0, 1);
    check("bp_accept_gap", 32'(last_acc - hs_cyc), 32'd1);
    finish_word(1'b1);
    rdy_mode = 0;

    start_word(15'h2a2a, 4'h5, 4'h5, 4'h5, 4'h4, 4'h6, 15'h0840, 1);
    t = 0;
    while (chien_pos != 4'd6 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_pos", 32'(chien_pos), 32'd6);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_chien_pos", 32'(chien_pos), 32'd0);
    run(15'h0403, 4'h9, 4'h1, 4'h0, 4'h7, 4'h3, 15'h0402, 2);

    for (int n = 0; n < 40; n++) begin
      typ = $urandom_range(0, 4);
      s1 = 4'($urandom); s2 = 4'($urandom); s3 = 4'($urandom);
      if ((s1 | s2 | s3) == 4'd0) s3 = 4'h1;
      l1 = 4'($urandom_range(1, 15));
      l2 = 4'($urandom_range(1, 15));
      p1 = $urandom_range(0, 14);
      p2 = (p1 + $urandom_range(1, 14)) % 15;
      roots = '0;
      case (typ)
        0: begin
          s1 = '0; s2 = '0; s3 = '0;
          roots = 15'($urandom);
        end
        1: begin
          l2 = '0;
          roots[p1] = 1'b1;
        end
        2: begin
          roots[p1] = 1'b1;
          roots[p2] = 1'b1;
        end
        3: roots = 15'($urandom) & 15'($urandom) & 15'($urandom);
        default: begin
          l1 = '0; l2 = '0;
          roots = 15'($urandom) & 15'($urandom);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(15'($urandom), s1, s2, s3, l1, l2, roots, $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
